seg7_disp_ctrl: RTL
===================

Name: seg7_disp_ctrl

Overview:
- Upstream driver for the 7-segment display device.
- Holds the CPU-writable display registers: hex value, decimal-point mask, blink mask and control.
- Generates the 3-bit digit scan index and the blink (flash) strobe.
- Commits new hex data only at scan-frame boundaries, so a digit frame never shows a mix of old and new data.

Parameters:
- SCAN_DIV_BITS, 17: prescaler width; Scan advances once every 2^SCAN_DIV_BITS clocks.
- FLASH_DIV_BITS, 25: blink prescaler width; flash toggles once every 2^FLASH_DIV_BITS clocks.
- RESET_HEX, 32'h0000_0000: reset value of the shadow and committed hex registers.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- we  in  1  register write strobe, single cycle.
- re  in  1  register read strobe, single cycle.
- addr  in  2  register select: 0 HEX, 1 POINT, 2 LES, 3 CTRL.
- wdata  in  32  write data.
- rdata  out  32  read data, registered.
- rvalid  out  1  high for one cycle when rdata is valid.
- Scan  out  3  digit scan index to the display device.
- flash  out  1  blink strobe to the display device.
- Hexs  out  32  committed hex value.
- point  out  8  decimal-point mask.
- LES  out  8  per-digit blink mask.
- SW0  out  1  text/graphic mode select (CTRL bit 2).
- pending  out  1  shadow hex not yet committed.

Behaviour:
- Reset, sampled on the clk edge with rst_n=0:
  - Scan=0, flash=0, Hexs=RESET_HEX, shadow=RESET_HEX.
  - point=0, LES=0, SW0=0, pending=0, rdata=0, rvalid=0.
  - Prescalers=0, CTRL=0 (flash_en=0, freeze=0).
- Reset mid-operation discards any pending commit and any in-flight read.
- Writes, effective the clock after we=1:
  - addr0: shadow<=wdata; pending<=1.
  - addr1: point<=wdata[7:0].
  - addr2: LES<=wdata[7:0].
  - addr3: flash_en<=wdata[0]; freeze<=wdata[1]; SW0<=wdata[2].
  - point, LES and CTRL take effect immediately; they are not shadowed.
- Scan prescaler:
  - Counter increments every clock.
  - When the counter is all ones, Scan<=Scan+1, wrapping 7->0.
- Commit:
  - The frame-end event is the cycle where the prescaler is all ones and Scan==7.
  - On frame-end with pending=1 and freeze=0: Hexs<=shadow and pending<=0.
  - With freeze=1, no commit occurs and pending stays 1.
- Simultaneous write to HEX on the frame-end cycle:
  - Commit uses the pre-write shadow.
  - Shadow takes wdata.
  - pending remains 1 (the write wins over the clear).
- Flash:
  - With flash_en=1: the flash prescaler counts, and flash toggles when the counter is all ones.
  - With flash_en=0: flash is held at 0 (no digit blanking) and the flash prescaler is cleared.
  - Re-enabling starts from flash=0 with the counter at 0.
- Reads: one-cycle latency. The cycle after re=1, rvalid=1 and rdata is:
  - addr0: shadow.
  - addr1: {24'b0, point}.
  - addr2: {24'b0, LES}.
  - addr3: {pending, 28'b0, SW0, freeze, flash_en}.
- At other times rvalid=0 and rdata holds its last value.
- Read and write in the same cycle to the same addr: read returns the pre-write value.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
All scenarios use SCAN_DIV_BITS=2 and FLASH_DIV_BITS=3.
- Reset: drive rst_n=0 for 2 clocks mid-count with pending=1 -> Scan=0, Hexs=0, pending=0, flash=0, rvalid=0 on the next edge.
- Scan cadence: free-run for 40 clocks -> Scan steps every 4 clocks through 0..7 and wraps to 0 at clock 32.
- Deferred commit: write HEX=0x1234ABCD while Scan=2 -> pending=1 and Hexs unchanged until frame-end; Hexs=0x1234ABCD and pending=0 on the following edge.
- Frame-end collision: write HEX=0xA while idle, then write HEX=0xB exactly on the frame-end cycle -> Hexs=0xA, shadow=0xB, pending=1; the next frame-end gives Hexs=0xB.
- Freeze: write CTRL=0x2, then HEX=0x55 -> Hexs unchanged across 3 frames. Write CTRL=0x0 -> Hexs=0x55 at the next frame-end.
- Flash and readback:
  - Write CTRL=0x5 -> SW0=1 and flash toggles every 8 clocks.
  - Read addr3 -> one clock later rvalid=1 and rdata=0x00000005.
  - Write CTRL=0x0 -> flash=0 on the next edge.

Source files
------------

// File: rtl/seg7_disp_ctrl.sv
// Purpose : register front-end and scan/blink timing for a 7-segment display device.
// Latency : register writes land the clock after we; reads return one clock after re;
//           new hex data reaches Hexs only at the next scan-frame boundary.
// Backpressure : none. we/re are single-cycle strobes that are always accepted.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   we, re, addr, wdata register write/read strobes, select (0 HEX, 1 POINT, 2 LES, 3 CTRL), data
//   rdata, rvalid       registered read data and its one-cycle valid
//   Scan, flash         digit scan index and blink strobe to the display device
//   Hexs, point, LES    committed hex value, decimal-point mask, per-digit blink mask
//   SW0, pending        text/graphic mode select, shadow hex awaiting commit
module seg7_disp_ctrl #(
   parameter int          SCAN_DIV_BITS  = 17,
   parameter int          FLASH_DIV_BITS = 25,
   parameter logic [31:0] RESET_HEX      = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we,
   input  logic        re,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        rvalid,
   output logic [2:0]  Scan,
   output logic        flash,
   output logic [31:0] Hexs,
   output logic [7:0]  point,
   output logic [7:0]  LES,
   output logic        SW0,
   output logic        pending
);

   localparam logic [SCAN_DIV_BITS-1:0]  SCAN_ONE  = SCAN_DIV_BITS'(1);
   localparam logic [FLASH_DIV_BITS-1:0] FLASH_ONE = FLASH_DIV_BITS'(1);

   logic [SCAN_DIV_BITS-1:0]  scan_cnt;
   logic [FLASH_DIV_BITS-1:0] flash_cnt;
   logic [31:0]               shadow;
   logic                      flash_en;
   logic                      freeze;

   logic        wr_hex, wr_point, wr_les, wr_ctrl;
   logic        scan_tick, frame_end, commit;
   logic        flash_en_nxt;
   logic [31:0] rd_mux;

   assign wr_hex   = we && (addr == 2'd0);
   assign wr_point = we && (addr == 2'd1);
   assign wr_les   = we && (addr == 2'd2);
   assign wr_ctrl  = we && (addr == 2'd3);

   assign scan_tick = &scan_cnt;
   // Last prescaler cycle of digit 7: the only point where swapping Hexs
   // cannot tear a frame.
   assign frame_end = scan_tick && (Scan == 3'd7);
   assign commit    = frame_end && pending && !freeze;

   // Disabling blink must blank flash on the same edge the CTRL write lands,
   // so the clear path looks at the value being written.
   assign flash_en_nxt = wr_ctrl ? wdata[0] : flash_en;

   always_comb begin
      rd_mux = 32'h0;
      case (addr)
         2'd0:    rd_mux = shadow;
         2'd1:    rd_mux = {24'h0, point};
         2'd2:    rd_mux = {24'h0, LES};
         default: rd_mux = {pending, 28'h0, SW0, freeze, flash_en};
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scan_cnt  <= '0;
         flash_cnt <= '0;
         Scan      <= 3'd0;
         flash     <= 1'b0;
         Hexs      <= RESET_HEX;
         shadow    <= RESET_HEX;
         pending   <= 1'b0;
         point     <= 8'h0;
         LES       <= 8'h0;
         SW0       <= 1'b0;
         flash_en  <= 1'b0;
         freeze    <= 1'b0;
         rdata     <= 32'h0;
         rvalid    <= 1'b0;
      end else begin
         scan_cnt <= scan_cnt + SCAN_ONE;
         if (scan_tick) begin
            Scan <= Scan + 3'd1;
         end

         // Commit samples the pre-write shadow; a HEX write on the same edge
         // is assigned afterwards so its pending set wins over the clear.
         if (commit) begin
            Hexs    <= shadow;
            pending <= 1'b0;
         end
         if (wr_hex) begin
            shadow  <= wdata;
            pending <= 1'b1;
         end

         if (wr_point) begin
            point <= wdata[7:0];
         end
         if (wr_les) begin
            LES <= wdata[7:0];
         end
         if (wr_ctrl) begin
            flash_en <= wdata[0];
            freeze   <= wdata[1];
            SW0      <= wdata[2];
         end

         // Counting only starts once flash_en is registered, so re-enabling
         // begins from flash=0 with an empty prescaler.
         if (!flash_en_nxt) begin
            flash_cnt <= '0;
            flash     <= 1'b0;
         end else if (flash_en) begin
            flash_cnt <= flash_cnt + FLASH_ONE;
            if (&flash_cnt) begin
               flash <= ~flash;
            end
         end

         rvalid <= re;
         if (re) begin
            rdata <= rd_mux;
         end
      end
   end

endmodule
